// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares one single-ported instruction/data memory between the multicycle CPU
// memory path and a debug/program-loader port. A three-state owner FSM
// (IDLE / CPU / DBG) grants the memory to one side at a time. When both sides
// want the memory, the owner keeps it for at most MAX_HOLD consecutive cycles.
// On a conflict out of IDLE, the side that did not own the memory last wins.
//
// Optional feature (macro IMEM_ARB_DBG_LOCK_EN):
//   Adds the dbg_lock input. While DBG owns the memory and dbg_lock is high,
//   ownership never leaves DBG. This supports atomic program loads.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata     CPU access request (held until granted)
//   cpu_gnt                   CPU access performed this cycle
//   cpu_stall                 cpu_req & ~cpu_gnt, freezes the CPU controller
//   cpu_rvalid/cpu_rdata      registered read data, valid the cycle after a read
//   dbg_*                     same set of ports for the debug/loader side
//   dbg_lock                  (optional) keep DBG ownership while high
//   mem_addr/wdata/we         muxed access toward the memory block
//   mem_rdata                 combinational read data from the memory block
//   owner                     FSM state: 00 IDLE, 01 CPU, 10 DBG
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef IMEM_ARB_DBG_LOCK_EN
   input  logic              dbg_lock,
`endif
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WIDTH-1:0]  cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [WIDTH-1:0]  cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [WIDTH-1:0]  dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_stall,
   output logic              dbg_rvalid,
   output logic [WIDTH-1:0]  dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic              mem_we,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DBG  = 2'b10
   } owner_t;

   // The owner may keep the memory while hold_cnt is below this limit.
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   owner_t             owner_q, owner_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;
   logic               last_dbg_q, last_dbg_d;   // 1: DBG owned the memory last
   logic               cpu_rvalid_q, cpu_rvalid_d;
   logic               dbg_rvalid_q, dbg_rvalid_d;
   logic [WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
   logic               dbg_lock_hold;

`ifdef IMEM_ARB_DBG_LOCK_EN
   assign dbg_lock_hold = (owner_q == OWN_DBG) & dbg_lock;
`else
   assign dbg_lock_hold = 1'b0;
`endif

   // Grants depend only on registered state and the live request. As a
   // result, an asynchronous reset removes them at once.
   assign cpu_gnt   = (owner_q == OWN_CPU) & cpu_req;
   assign dbg_gnt   = (owner_q == OWN_DBG) & dbg_req;
   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign dbg_stall = dbg_req & ~dbg_gnt;
   assign owner     = owner_q;

   assign cpu_rvalid = cpu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;

   // Memory mux: drive zeros when no side holds a grant.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end else if (dbg_gnt) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_we    = dbg_we;
      end
   end

   // Next owner, hold counter and last-owner memory
   always_comb begin
      owner_d    = owner_q;
      hold_cnt_d = hold_cnt_q;
      last_dbg_d = last_dbg_q;

      case (owner_q)
         OWN_IDLE: begin
            if (cpu_req && dbg_req) owner_d = last_dbg_q ? OWN_CPU : OWN_DBG;
            else if (cpu_req)       owner_d = OWN_CPU;
            else if (dbg_req)       owner_d = OWN_DBG;
         end
         OWN_CPU: begin
            if (cpu_req && (!dbg_req || hold_cnt_q < HOLD_LIM)) owner_d = OWN_CPU;
            else if (dbg_req)                                  owner_d = OWN_DBG;
            else                                               owner_d = OWN_IDLE;
         end
         OWN_DBG: begin
            if (dbg_lock_hold)                                  owner_d = OWN_DBG;
            else if (dbg_req && (!cpu_req || hold_cnt_q < HOLD_LIM)) owner_d = OWN_DBG;
            else if (cpu_req)                                   owner_d = OWN_CPU;
            else                                                owner_d = OWN_IDLE;
         end
         default: owner_d = OWN_IDLE;
      endcase

      if (owner_d != owner_q) begin
         hold_cnt_d = 8'd0;
         if (owner_q == OWN_CPU) last_dbg_d = 1'b0;
         if (owner_q == OWN_DBG) last_dbg_d = 1'b1;
      end else if (owner_q != OWN_IDLE && hold_cnt_q != 8'hFF) begin
         hold_cnt_d = hold_cnt_q + 8'd1;
      end
   end

   // Read capture: rdata keeps its value until the next read by that side.
   always_comb begin
      cpu_rvalid_d = cpu_gnt & ~cpu_we;
      dbg_rvalid_d = dbg_gnt & ~dbg_we;
      cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
      dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q      <= OWN_IDLE;
         hold_cnt_q   <= 8'd0;
         last_dbg_q   <= 1'b1;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         hold_cnt_q   <= hold_cnt_d;
         last_dbg_q   <= last_dbg_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-ported instruction/data memory between the multicycle CPU memory path and a debug/program-loader port.
- Sits between the IorD-mux/MemWrite path and the memory block, and returns per-requester read data.
- Uses a 3-state owner FSM with round-robin on conflict and a bounded hold count so neither side starves.
- Exposes cpu_stall so the CPU controller can freeze its state while waiting.

Parameters:
- WIDTH, 32, data width of requesters and memory.
- ADDR_W, 5, memory word-address width.
- MAX_HOLD, 8, maximum consecutive owner cycles while the other side waits; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held until granted.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  ADDR_W  CPU word address.
- cpu_wdata  input  WIDTH  CPU write data.
- cpu_gnt  output  1  CPU access performed this cycle.
- cpu_stall  output  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  output  1  pulses the cycle after a CPU read grant.
- cpu_rdata  output  WIDTH  registered read data for the CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug/loader side.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  WIDTH  write data to memory.
- mem_we  output  1  memory write enable.
- mem_rdata  input  WIDTH  combinational memory read data.
- owner  output  2  FSM state: 00 IDLE, 01 CPU, 10 DBG.

Behaviour:
- Reset (rst=0, asynchronous): owner=IDLE, hold_cnt=0, last_owner=DBG (so the CPU wins the first conflict).
- Reset values of outputs: all gnt/rvalid=0, all rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- A reset asserted mid-access drops gnt and mem_we immediately; no partial write is committed.
- Grants are combinational from state: cpu_gnt = (owner==CPU) & cpu_req; dbg_gnt = (owner==DBG) & dbg_req.
- Memory mux: mem_addr, mem_wdata and mem_we = gnt & we come from the granted side. With no grant, mem_we=0 and addr/wdata=0.
- A write commits at the rising edge that ends the grant cycle.
- Reads: on a read grant, mem_rdata is registered into xxx_rdata, and xxx_rvalid=1 for exactly the next cycle. rdata holds its value until the next read by that side.
- Request-to-grant latency: 1 cycle from IDLE; 0 cycles if already owner.
- FSM transitions from IDLE:
  - both req -> side opposite last_owner;
  - one req -> that side;
  - none -> stay IDLE.
- FSM transitions from CPU (DBG symmetric):
  - cpu_req & ~dbg_req -> stay;
  - cpu_req & dbg_req & hold_cnt<MAX_HOLD-1 -> stay;
  - dbg_req & (~cpu_req | hold_cnt==MAX_HOLD-1) -> DBG;
  - neither -> IDLE.
- hold_cnt: 8-bit; clears on any owner change; otherwise increments each cycle in CPU/DBG and saturates at 255.
- last_owner updates when leaving CPU or DBG.
- MAX_HOLD=1 gives strict cycle-by-cycle alternation under continuous contention.
- Requests may change addr/we only while not stalled. Dropping req without a grant is legal, and no access occurs.
- Both sides addressing the same word: accesses are ordered by grant order, and a read sees all earlier granted writes.

Optional Feature:
- IMEM_ARB_DBG_LOCK_EN defined:
  - adds input dbg_lock (1 bit);
  - while owner==DBG and dbg_lock=1, the FSM never leaves DBG, even with dbg_req low or hold_cnt at the limit;
  - cpu_stall stays high for any cpu_req; used for atomic program load;
  - on lock release, normal rules apply next cycle.
- Undefined: no dbg_lock port; behaviour exactly as above.

Test Plan:
- Reset then cpu_req=1, cpu_we=0, cpu_addr=3, mem[3]=0x8C220004 -> owner=CPU next cycle, cpu_gnt=1; next cycle cpu_rvalid=1, cpu_rdata=0x8C220004.
- dbg writes 0xDEADBEEF to addr 7, then CPU reads addr 7 -> mem_we=1 for one cycle with mem_addr=7; CPU later reads 0xDEADBEEF.
- Both req continuously from reset, MAX_HOLD=8 -> CPU granted 8 cycles, DBG 8, CPU 8...; cpu_stall=1 exactly during DBG windows.
- Both req, MAX_HOLD=1 -> owner alternates 01,10,01,10 every cycle; no rvalid lost.
- DBG write granted, rst pulled low mid-cycle before the edge -> mem_we=0 at once, target word unchanged, all outputs at reset values.
- With IMEM_ARB_DBG_LOCK_EN: dbg_lock=1 while owner=DBG, cpu_req=1 for 20 cycles -> cpu_gnt stays 0; lock drops -> CPU granted within 2 cycles.
